mips_multicycle_control: RTL and testbench

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

---
 rtl/mips_multicycle_control.sv | 159 +++++++++++++++
 tb/tb_mips_multicycle_control.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore control FSM for a multicycle MIPS datapath; define MC_ADDI_EN to add addi (ADDIEX/ADDIWB)
module mips_multicycle_control (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       branch_o,
    output logic       iord_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_src_o,
    output logic [1:0] alu_op_o,
    output logic [3:0] state_o,
    output logic       illegal_op_o
);
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_RT  = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXECUTE = 4'd6;
    localparam logic [3:0] ALUWB   = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] JUMP    = 4'd11;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
`endif

    logic [3:0] state;
    logic [3:0] next_state;
    logic [3:0] decode_target;
    logic [5:0] op_q;
    logic       illegal_q;

    // Opcode dispatch out of DECODE; FETCH as a target means the opcode is unsupported
    always_comb begin
        case (op_i)
            OP_LW, OP_SW: decode_target = MEMADR;
            OP_RT:        decode_target = EXECUTE;
            OP_BEQ:       decode_target = BRANCH;
            OP_J:         decode_target = JUMP;
`ifdef MC_ADDI_EN
            OP_ADDI:      decode_target = ADDIEX;
`endif
            default:      decode_target = FETCH;
        endcase
    end

    // State register, opcode latched on DECODE exit, sticky illegal-opcode flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= FETCH;
            op_q      <= 6'd0;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == DECODE) begin
                op_q      <= op_i;
                illegal_q <= illegal_q | (decode_target == FETCH);
            end
        end
    end

    // Next-state logic; memory states wait for mem_ready_i, unused encodings fall back to FETCH
    always_comb begin
        case (state)
            FETCH:   next_state = mem_ready_i ? DECODE : FETCH;
            DECODE:  next_state = decode_target;
            MEMADR:  next_state = (op_q == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   next_state = mem_ready_i ? MEMWB : MEMRD;
            MEMWR:   next_state = mem_ready_i ? FETCH : MEMWR;
            EXECUTE: next_state = ALUWB;
`ifdef MC_ADDI_EN
            ADDIEX:  next_state = ADDIWB;
`endif
            default: next_state = FETCH;
        endcase
    end

    // Moore outputs; only the FETCH writes are gated by the memory handshake
    always_comb begin
        pc_write_o   = 1'b0;
        branch_o     = 1'b0;
        iord_o       = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        pc_src_o     = 2'b00;
        alu_op_o     = 2'b00;
        case (state)
            FETCH: begin
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            DECODE:  alu_src_b_o = 2'b11;
            MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            MEMRD:   iord_o = 1'b1;
            MEMWB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
            end
            MEMWR: begin
                iord_o      = 1'b1;
                mem_write_o = 1'b1;
            end
            EXECUTE: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b10;
            end
            ALUWB: begin
                reg_dst_o   = 1'b1;
                reg_write_o = 1'b1;
            end
            BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b01;
                pc_src_o    = 2'b01;
                branch_o    = 1'b1;
            end
`ifdef MC_ADDI_EN
            ADDIEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            ADDIWB:  reg_write_o = 1'b1;
`endif
            JUMP: begin
                pc_src_o   = 2'b10;
                pc_write_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o      = state;
    assign illegal_op_o = illegal_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed vector table, async-reset corner cases and randomized run against a per-instruction sequence model
module tb_mips_multicycle_control;
    localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MWB = 4'd4, S_MWR = 4'd5;
    localparam logic [3:0] S_EX = 4'd6, S_AWB = 4'd7, S_BR = 4'd8, S_AIE = 4'd9, S_AIW = 4'd10, S_J = 4'd11, S_END = 4'd15;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, ILL = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [5:0] op_i;
    logic       mem_ready_i;
    logic       pc_write_o, branch_o, iord_o, mem_write_o, ir_write_o;
    logic       reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o;
    logic [1:0] alu_src_b_o, pc_src_o, alu_op_o;
    logic [3:0] state_o;
    logic       illegal_op_o;
    logic [14:0] dut_out;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .branch_o(branch_o), .iord_o(iord_o), .mem_write_o(mem_write_o),
        .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
        .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .pc_src_o(pc_src_o), .alu_op_o(alu_op_o), .state_o(state_o), .illegal_op_o(illegal_op_o)
    );

    assign dut_out = {pc_write_o, branch_o, iord_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
                      reg_write_o, alu_src_a_o, alu_src_b_o, pc_src_o, alu_op_o};

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
        logic       ill;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic [5:0] op, logic rdy, logic [3:0] st, logic ill);
        vec_t v;
        v.op = op;
        v.rdy = rdy;
        v.st = st;
        v.ill = ill;
        return v;
    endfunction

    // Control word each state must present, listed field by field
    function automatic logic [14:0] exp_out(logic [3:0] st, logic rdy);
        logic pw, br, io, mw, iw, rd, mr, rw, sa;
        logic [1:0] sb, ps, ao;
        {pw, br, io, mw, iw, rd, mr, rw, sa} = 9'd0;
        {sb, ps, ao} = 6'd0;
        case (st)
            S_F:   begin sb = 2'b01; iw = rdy; pw = rdy; end
            S_D:   sb = 2'b11;
            S_MA:  begin sa = 1'b1; sb = 2'b10; end
            S_MR:  io = 1'b1;
            S_MWB: begin mr = 1'b1; rw = 1'b1; end
            S_MWR: begin io = 1'b1; mw = 1'b1; end
            S_EX:  begin sa = 1'b1; ao = 2'b10; end
            S_AWB: begin rd = 1'b1; rw = 1'b1; end
            S_BR:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; end
`ifdef MC_ADDI_EN
            S_AIE: begin sa = 1'b1; sb = 2'b10; end
            S_AIW: rw = 1'b1;
`endif
            S_J:   begin ps = 2'b10; pw = 1'b1; end
            default: ;
        endcase
        return {pw, br, io, mw, iw, rd, mr, rw, sa, sb, ps, ao};
    endfunction

    // Zero-stall state list of one instruction; S_END past its last state
    function automatic logic [3:0] seq_state(logic [5:0] op, int pos);
        logic [3:0] s [0:4];
        for (int i = 0; i < 5; i++) s[i] = S_END;
        s[0] = S_F;
        s[1] = S_D;
        case (op)
            LW:  begin s[2] = S_MA; s[3] = S_MR; s[4] = S_MWB; end
            SW:  begin s[2] = S_MA; s[3] = S_MWR; end
            RT:  begin s[2] = S_EX; s[3] = S_AWB; end
            BEQ: s[2] = S_BR;
            JMP: s[2] = S_J;
`ifdef MC_ADDI_EN
            ADDI: begin s[2] = S_AIE; s[3] = S_AIW; end
`endif
            default: ;
        endcase
        return (pos < 5) ? s[pos] : S_END;
    endfunction

    function automatic logic [5:0] pick();
        case ($urandom_range(0, 6))
            0: return LW;
            1: return SW;
            2: return RT;
            3: return BEQ;
            4: return JMP;
            5: return ADDI;
            default: return 6'($urandom);
        endcase
    endfunction

    task automatic chk(string tag, logic [3:0] est, logic rdy, logic eill);
        logic [14:0] eo;
        eo = exp_out(est, rdy);
        n_chk += 3;
        if (state_o !== est) begin
            n_fail++;
            $display("FAIL %s state: got %0d expected %0d", tag, state_o, est);
        end
        if (dut_out !== eo) begin
            n_fail++;
            $display("FAIL %s outputs: got %b expected %b (state %0d)", tag, dut_out, eo, est);
        end
        if (illegal_op_o !== eill) begin
            n_fail++;
            $display("FAIL %s illegal_op: got %b expected %b", tag, illegal_op_o, eill);
        end
    endtask

    initial begin
        logic [5:0] cur;
        logic [3:0] est;
        logic ill;
        int pos;
        rst_i = 1'b1;
        op_i = 6'd0;
        mem_ready_i = 1'b0;
        #1 chk("reset", S_F, 1'b0, 1'b0);
        // lw, sw with a 3-cycle write stall, R-type after a fetch stall, beq, j, illegal then lw
        tbl.push_back(mk(LW, 1, S_F, 0));   tbl.push_back(mk(LW, 1, S_D, 0));
        tbl.push_back(mk(RT, 1, S_MA, 0));  tbl.push_back(mk(RT, 1, S_MR, 0));
        tbl.push_back(mk(RT, 1, S_MWB, 0));
        tbl.push_back(mk(SW, 1, S_F, 0));   tbl.push_back(mk(SW, 1, S_D, 0));
        tbl.push_back(mk(LW, 1, S_MA, 0));  tbl.push_back(mk(SW, 0, S_MWR, 0));
        tbl.push_back(mk(SW, 0, S_MWR, 0)); tbl.push_back(mk(SW, 0, S_MWR, 0));
        tbl.push_back(mk(SW, 1, S_MWR, 0));
        tbl.push_back(mk(RT, 0, S_F, 0));   tbl.push_back(mk(RT, 1, S_F, 0));
        tbl.push_back(mk(RT, 1, S_D, 0));   tbl.push_back(mk(RT, 1, S_EX, 0));
        tbl.push_back(mk(RT, 1, S_AWB, 0));
        tbl.push_back(mk(BEQ, 1, S_F, 0));  tbl.push_back(mk(BEQ, 1, S_D, 0));
        tbl.push_back(mk(BEQ, 1, S_BR, 0));
        tbl.push_back(mk(JMP, 1, S_F, 0));  tbl.push_back(mk(JMP, 1, S_D, 0));
        tbl.push_back(mk(JMP, 1, S_J, 0));
        tbl.push_back(mk(ILL, 1, S_F, 0));  tbl.push_back(mk(ILL, 1, S_D, 0));
        tbl.push_back(mk(LW, 1, S_F, 1));   tbl.push_back(mk(LW, 1, S_D, 1));
        tbl.push_back(mk(SW, 1, S_MA, 1));  tbl.push_back(mk(SW, 1, S_MR, 1));
        tbl.push_back(mk(SW, 1, S_MWB, 1)); tbl.push_back(mk(RT, 0, S_F, 1));
        @(negedge clk);
        rst_i = 1'b0;
        foreach (tbl[i]) begin
            @(negedge clk);
            op_i = tbl[i].op;
            mem_ready_i = tbl[i].rdy;
            #1 chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].rdy, tbl[i].ill);
        end
        // Asynchronous reset while stalled in MEMRD, then first edge after release
        @(negedge clk);
        rst_i = 1'b1;
        #1 chk("rst_clr", S_F, mem_ready_i, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;
        op_i = LW;
        mem_ready_i = 1'b1;
        #1 chk("ar_f", S_F, 1'b1, 1'b0);
        @(negedge clk); #1 chk("ar_d", S_D, 1'b1, 1'b0);
        @(negedge clk); op_i = RT; #1 chk("ar_ma", S_MA, 1'b1, 1'b0);
        @(negedge clk); mem_ready_i = 1'b0; #1 chk("ar_mr0", S_MR, 1'b0, 1'b0);
        @(negedge clk); #1 chk("ar_mr1", S_MR, 1'b0, 1'b0);
        #2 rst_i = 1'b1;
        #1 chk("async_rst", S_F, 1'b0, 1'b0);
        @(negedge clk);
        op_i = LW;
        mem_ready_i = 1'b1;
        #1 chk("rst_held", S_F, 1'b1, 1'b0);
        #1 rst_i = 1'b0;
        @(posedge clk);
        #1 chk("first_edge", S_D, 1'b1, 1'b0);
        @(negedge clk);
        rst_i = 1'b1;
        mem_ready_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        // Randomized instruction stream with random memory stalls
        ill = 1'b0;
        pos = 0;
        cur = pick();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            est = seq_state(cur, pos);
            op_i = (est == S_D) ? cur : 6'($urandom);
            mem_ready_i = ($urandom_range(0, 3) != 0);
            #1 chk($sformatf("rand%0d", c), est, mem_ready_i, ill);
            if (!((est == S_F || est == S_MR || est == S_MWR) && !mem_ready_i)) begin
                if (est == S_D && seq_state(cur, 2) == S_END) ill = 1'b1;
                pos++;
                if (seq_state(cur, pos) == S_END) begin
                    pos = 0;
                    cur = pick();
                end
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
